mul_share_arbiter: RTL and testbench

Shares one combinational `wallace_tree_24x24` multiplier between two requesters through a round-robin arbiter and a 2-stage pipeline. The block registers the tree's carry-save output in stage 1 and resolves it into a 48-bit product in stage 2. It returns each product tagged with its requester ID on a single valid/ready response channel. It sits between the mantissa-producing units and the downstream normalise/round logic.

---
 rtl/mul_pkg.sv | 16 +
 rtl/rr_arb2.sv | 15 +
 rtl/wallace_tree_24x24.sv | 22 ++
 rtl/mul_share_arbiter.sv | 84 ++++++++
 tb/tb_mul_share_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and the stage-1 carry-save bundle for the shared multiplier
package mul_pkg;
    localparam int MUL_W  = 24;
    localparam int PROD_W = 48;
    localparam int CSA_LO = 8;
    localparam int CSA_W  = PROD_W - CSA_LO;
    localparam int HALF_W = MUL_W / 2;

    typedef struct packed {
        logic             valid;
        logic             id;
        logic [CSA_W-1:0] d;
        logic [CSA_W-1:0] f;
        logic [CSA_LO-1:0] g;
    } s1_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter, round-robin by prio or fixed priority to channel 0
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] grant
);
    // One-hot grant; a lone requester always wins, contention is settled by prio.
    always_comb begin
        grant = 2'b00;
        if (en) grant = &valid ? ((RR_EN && prio) ? 2'b10 : 2'b01) : valid;
    end
endmodule

// File: rtl/wallace_tree_24x24.sv
// wallace_tree_24x24: combinational 24x24 multiplier leaving the upper 40 bits in carry-save form
module wallace_tree_24x24
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [CSA_W-1:0]  d,
    output logic [CSA_W-1:0]  f,
    output logic [CSA_LO-1:0] g
);
    logic [MUL_W+HALF_W-1:0] lo;
    logic [MUL_W+HALF_W-1:0] hi;

    // Two partial-product rows; hi is weighted by 2^12 so its bits below 8 are zero and g is exact.
    always_comb begin
        lo = (MUL_W+HALF_W)'(a) * (MUL_W+HALF_W)'(b[HALF_W-1:0]);
        hi = (MUL_W+HALF_W)'(a) * (MUL_W+HALF_W)'(b[MUL_W-1:HALF_W]);
        g  = lo[CSA_LO-1:0];
        d  = CSA_W'(lo[MUL_W+HALF_W-1:CSA_LO]);
        f  = {hi, (HALF_W-CSA_LO)'(0)};
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: one 24x24 multiplier shared by two requesters through a 2-stage pipeline
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [MUL_W-1:0]  req0_a,
    input  logic [MUL_W-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [MUL_W-1:0]  req1_a,
    input  logic [MUL_W-1:0]  req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_p
);
    logic              prio;
    s1_t               s1;
    logic              s2_valid;
    logic              s2_id;
    logic [PROD_W-1:0] s2_p;
    logic              en1;
    logic              en2;
    logic [1:0]        grant;
    logic              winner;
    logic              transfer;
    logic [MUL_W-1:0]  a;
    logic [MUL_W-1:0]  b;
    logic [CSA_W-1:0]  d;
    logic [CSA_W-1:0]  f;
    logic [CSA_LO-1:0] g;

    assign en2 = !s2_valid || rsp_ready;
    assign en1 = !s1.valid || en2;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .valid ({req1_valid, req0_valid}),
        .prio  (prio),
        .en    (en1 && !rst),
        .grant (grant)
    );

    assign {req1_ready, req0_ready} = grant;
    assign transfer = |grant;
    assign winner   = grant[1];
    assign a = winner ? req1_a : req0_a;
    assign b = winner ? req1_b : req0_b;

    wallace_tree_24x24 u_tree (
        .a (a),
        .b (b),
        .d (d),
        .f (f),
        .g (g)
    );

    // Priority flip, carry-save capture in stage 1, and the 40-bit resolve in stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= 1'b0;
            s1       <= '0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_p     <= '0;
        end else begin
            if (transfer) prio <= !winner;
            if (en1) s1 <= '{valid: transfer, id: winner, d: d, f: f, g: g};
            if (en2) begin
                s2_valid <= s1.valid;
                s2_id    <= s1.id;
                s2_p     <= {CSA_W'(s1.d + s1.f), s1.g};
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_p     = s2_p;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: table vectors, directed corner sequences and random traffic against a queue model
module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [23:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [47:0] rsp_p;
    logic        f_r0, f_r1, f_v, f_id;
    logic [47:0] f_p;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          st;
        logic        id;
        logic [47:0] p;
    } item_t;
    item_t q[$];
    logic  prio_m = 1'b0;

    logic [1:0]  last_g, last_g0;
    logic        hold = 1'b0;
    logic        hold_id;
    logic [47:0] hold_p;

    typedef struct {
        logic        ch;
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    mul_share_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p)
    );

    mul_share_arbiter #(.RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_r0), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(f_r1), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(f_v), .rsp_ready(rsp_ready), .rsp_id(f_id), .rsp_p(f_p)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check combinational outputs at the falling edge, advance the model across the rising edge.
    task automatic step();
        logic [1:0]  eg;
        logic        ev, can;
        logic [47:0] ea, eb;
        @(negedge clk);
        can = (q.size() < 2) || rsp_ready;
        eg = (rst || !can) ? 2'b00 :
             (req0_valid && req1_valid) ? (prio_m ? 2'b10 : 2'b01) : {req1_valid, req0_valid};
        last_g  = {req1_ready, req0_ready};
        last_g0 = {f_r1, f_r0};
        check("ready", {46'd0, last_g}, {46'd0, eg});
        ev = q.size() > 0 && q[0].st == 2;
        check("rsp_valid", {47'd0, rsp_valid}, {47'd0, ev});
        if (ev) begin
            check("rsp_id", {47'd0, rsp_id}, {47'd0, q[0].id});
            check("rsp_p", rsp_p, q[0].p);
        end
        if (hold) begin
            check("hold_p", rsp_p, hold_p);
            check("hold_id", {47'd0, rsp_id}, {47'd0, hold_id});
        end
        hold    = rsp_valid && !rsp_ready && !rst;
        hold_p  = rsp_p;
        hold_id = rsp_id;
        if (rst) begin
            q.delete();
            prio_m = 1'b0;
        end else begin
            if (ev && rsp_ready) void'(q.pop_front());
            if (q.size() > 0 && q[0].st == 1) q[0].st = 2;
            if (eg != 2'b00) begin
                ea = eg[1] ? {24'd0, req1_a} : {24'd0, req0_a};
                eb = eg[1] ? {24'd0, req1_b} : {24'd0, req0_b};
                q.push_back('{st: 1, id: eg[1], p: ea * eb});
                prio_m = !eg[1];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b0, 24'h000003, 24'h000005, 48'd15};
        tbl[1] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
        tbl[2] = '{1'b0, 24'h000100, 24'h000100, 48'h000000010000};
        tbl[3] = '{1'b1, 24'h800000, 24'h000002, 48'h000001000000};
        tbl[4] = '{1'b0, 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF};
        tbl[5] = '{1'b1, 24'h000000, 24'hFFFFFF, 48'h000000000000};
        tbl[6] = '{1'b0, 24'h123456, 24'h000010, 48'h000001234560};
        idle();
        rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_valid", {47'd0, rsp_valid}, 48'd0);
        check("reset_p", rsp_p, 48'd0);
        check("reset_id", {47'd0, rsp_id}, 48'd0);

        foreach (tbl[i]) begin
            req0_valid = !tbl[i].ch;
            req1_valid = tbl[i].ch;
            req0_a = tbl[i].a; req0_b = tbl[i].b;
            req1_a = tbl[i].a; req1_b = tbl[i].b;
            step();
            check("tbl_grant", {46'd0, last_g}, tbl[i].ch ? 48'd2 : 48'd1);
            idle();
            step();
            check("tbl_valid", {47'd0, rsp_valid}, 48'd1);
            check("tbl_p", rsp_p, tbl[i].p);
            check("tbl_id", {47'd0, rsp_id}, {47'd0, tbl[i].ch});
            step();
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_a = 24'(i + 1);     req0_b = 24'h000011;
            req1_a = 24'(24'h100 + i); req1_b = 24'h000003;
            step();
            check("rr_grant", {46'd0, last_g}, (i % 2 == 1) ? 48'd2 : 48'd1);
            check("fixed_grant", {46'd0, last_g0}, 48'd1);
        end
        idle();
        repeat (3) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            req0_a = 24'(24'h0A0000 + i); req0_b = 24'h000777;
            req1_a = 24'(24'h0B0000 + i); req1_b = 24'h000999;
            step();
            if (last_g != 2'b00) n++;
        end
        check("bp_transfers", 48'(n), 48'd2);
        check("bp_ready_low", {46'd0, last_g}, 48'd0);
        rsp_ready = 1'b1;
        idle();
        repeat (4) step();

        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_valid", {47'd0, rsp_valid}, 48'd0);
        check("midrst_p", rsp_p, 48'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("midrst_grant", {46'd0, last_g}, 48'd1);

        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_a = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            req0_b = 24'($urandom);
            req1_a = 24'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            step();
        end
        idle();
        rsp_ready = 1'b1;
        repeat (3) step();
        check("drained", 48'(q.size()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
